// File: rtl/pnr_pulse_classifier_if.sv
// Bus bundle for the photon-number pulse classifier: ADC stream, thresholds, result strobe.
// Histogram readout signals exist only when PNR_HISTOGRAM_EN is defined.
interface pnr_pulse_classifier_if;
   localparam int unsigned ADC_W = 14;
   localparam int unsigned NUM_W = 3;
   localparam int unsigned CNT_W = 32;

   logic [ADC_W-1:0] adc_dat_i;
   logic [ADC_W-1:0] adc_photon_threshold_1;
   logic [ADC_W-1:0] adc_photon_threshold_2;
   logic [ADC_W-1:0] adc_photon_threshold_3;
   logic [ADC_W-1:0] adc_photon_threshold_4;
   logic [ADC_W-1:0] adc_photon_threshold_5;
   logic [ADC_W-1:0] adc_photon_threshold_6;
   logic [ADC_W-1:0] adc_photon_threshold_7;
   logic [NUM_W-1:0] photon_num_o;
   logic             photon_valid_o;
   logic             overlong_o;
   logic             busy_o;
`ifdef PNR_HISTOGRAM_EN
   logic             hist_clr_i;
   logic [NUM_W-1:0] hist_sel_i;
   logic [CNT_W-1:0] hist_cnt_o;
`endif

   modport master (
`ifdef PNR_HISTOGRAM_EN
      output hist_clr_i, hist_sel_i,
      input  hist_cnt_o,
`endif
      output adc_dat_i,
      output adc_photon_threshold_1, adc_photon_threshold_2, adc_photon_threshold_3,
      output adc_photon_threshold_4, adc_photon_threshold_5, adc_photon_threshold_6,
      output adc_photon_threshold_7,
      input  photon_num_o, photon_valid_o, overlong_o, busy_o
   );

   modport slave (
`ifdef PNR_HISTOGRAM_EN
      input  hist_clr_i, hist_sel_i,
      output hist_cnt_o,
`endif
      input  adc_dat_i,
      input  adc_photon_threshold_1, adc_photon_threshold_2, adc_photon_threshold_3,
      input  adc_photon_threshold_4, adc_photon_threshold_5, adc_photon_threshold_6,
      input  adc_photon_threshold_7,
      output photon_num_o, photon_valid_o, overlong_o, busy_o
   );
endinterface

// File: rtl/pnr_pulse_classifier.sv
// Detects ADC pulses above threshold 1, tracks the peak and classifies it into photon number 1..7.
// Optional photon-number histogram is built when PNR_HISTOGRAM_EN is defined.
module pnr_pulse_classifier #(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned HOLDOFF = 8
) (
   input logic                   clk_i,
   input logic                   rstn_i,
   pnr_pulse_classifier_if.slave bus
);
   localparam int unsigned ADC_W   = 14;
   localparam int unsigned NUM_W   = 3;
   localparam int unsigned LEN_W   = 12;
   localparam int unsigned HO_W    = $clog2(HOLDOFF + 2);
   localparam int unsigned HO_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
   localparam int unsigned NTHR    = 7;

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

   state_t                  state, state_nx;
   logic signed [ADC_W-1:0] adc_r;
   logic                    prev_above;
   logic signed [ADC_W-1:0] peak;
   logic        [LEN_W-1:0] len;
   logic        [HO_W-1:0]  ho_cnt;
   logic signed [ADC_W-1:0] shadow  [NTHR];
   logic signed [ADC_W-1:0] thr_bus [NTHR];
   logic        [NUM_W-1:0] num_q;
   logic                    valid_q;
   logic                    ovl_q;
   logic                    busy_q;

   logic                    above_bus_c;
   logic                    above_sh_c;
   logic signed [ADC_W-1:0] peak_nx_c;
   logic        [LEN_W-1:0] len_inc_c;
   logic        [NUM_W-1:0] cls_c;
   logic                    start_c;
   logic                    extend_c;
   logic                    decide_c;
   logic                    ovl_c;

   assign thr_bus[0] = bus.adc_photon_threshold_1;
   assign thr_bus[1] = bus.adc_photon_threshold_2;
   assign thr_bus[2] = bus.adc_photon_threshold_3;
   assign thr_bus[3] = bus.adc_photon_threshold_4;
   assign thr_bus[4] = bus.adc_photon_threshold_5;
   assign thr_bus[5] = bus.adc_photon_threshold_6;
   assign thr_bus[6] = bus.adc_photon_threshold_7;

   // Falling samples are below shadow_thr1 < peak, so max() leaves peak unchanged then.
   always_comb begin
      above_bus_c = adc_r > thr_bus[0];
      above_sh_c  = adc_r > shadow[0];
      peak_nx_c   = (adc_r > peak) ? adc_r : peak;
      len_inc_c   = len + LEN_W'(1);
      cls_c       = '0;
      for (int k = 0; k < NTHR; k++) begin
         if (peak_nx_c > shadow[k]) cls_c = cls_c + NUM_W'(1);
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_nx = state;
      start_c  = 1'b0;
      extend_c = 1'b0;
      decide_c = 1'b0;
      ovl_c    = 1'b0;
      case (state)
         IDLE: begin
            if (above_bus_c && !prev_above) begin
               start_c  = 1'b1;
               state_nx = PULSE;
            end
         end
         PULSE: begin
            if (above_sh_c) begin
               extend_c = 1'b1;
               if (len_inc_c == LEN_W'(MAX_LEN)) begin
                  decide_c = 1'b1;
                  ovl_c    = 1'b1;
               end
            end else begin
               decide_c = 1'b1;
            end
            if (decide_c) state_nx = (HOLDOFF == 0) ? IDLE : HOLD;
         end
         HOLD: begin
            if (ho_cnt == HO_W'(HO_LAST)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         adc_r      <= '0;
         prev_above <= 1'b0;
         peak       <= '0;
         len        <= '0;
         ho_cnt     <= '0;
         num_q      <= '0;
         valid_q    <= 1'b0;
         ovl_q      <= 1'b0;
         busy_q     <= 1'b0;
         for (int k = 0; k < NTHR; k++) shadow[k] <= '0;
      end else begin
         state      <= state_nx;
         adc_r      <= $signed(bus.adc_dat_i);
         prev_above <= above_bus_c;
         valid_q    <= decide_c;
         busy_q     <= (state_nx != IDLE);
         if (start_c) begin
            for (int k = 0; k < NTHR; k++) shadow[k] <= thr_bus[k];
            peak <= adc_r;
            len  <= LEN_W'(1);
         end
         if (extend_c) begin
            peak <= peak_nx_c;
            len  <= len_inc_c;
         end
         if (decide_c) begin
            num_q  <= cls_c;
            ovl_q  <= ovl_c;
            ho_cnt <= '0;
         end else if (state == HOLD) begin
            ho_cnt <= ho_cnt + HO_W'(1);
         end
      end
   end

   assign bus.photon_num_o   = num_q;
   assign bus.photon_valid_o = valid_q;
   assign bus.overlong_o     = ovl_q;
   assign bus.busy_o         = busy_q;

`ifdef PNR_HISTOGRAM_EN
   localparam int unsigned CNT_W = 32;

   logic [CNT_W-1:0] bins [8];
   logic [CNT_W-1:0] hist_cnt_q;
   logic [NUM_W-1:0] bin_c;

   // Overlong pulses go to bin 0 regardless of their photon number.
   assign bin_c = ovl_q ? NUM_W'(0) : num_q;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         hist_cnt_q <= '0;
         for (int b = 0; b < 8; b++) bins[b] <= '0;
      end else begin
         if (bus.hist_clr_i) begin
            for (int b = 0; b < 8; b++) bins[b] <= '0;
         end else if (valid_q && (bins[bin_c] != '1)) begin
            bins[bin_c] <= bins[bin_c] + CNT_W'(1);
         end
         hist_cnt_q <= bins[bus.hist_sel_i];
      end
   end

   assign bus.hist_cnt_o = hist_cnt_q;
`endif
endmodule

// File: doc/pnr_pulse_classifier.md
# pnr_pulse_classifier

Photon-number-resolving discriminator that consumes the seven ADC photon thresholds from the PNR register bank and the 14-bit ADC sample stream. It detects each detector pulse, tracks its peak, and classifies it into a photon number 1..7 by comparing the peak against the thresholds. It emits one result strobe per pulse. Optional per-bin counters accumulate a photon-number histogram for readout.

## Interface
- MAX_LEN, 64: maximum pulse length in samples before a forced decision; range 2..4095.
- HOLDOFF, 8: dead-time cycles after each decision; 0 allowed.
- clk_i input 1: processing clock.
- rstn_i input 1: reset; synchronous, active-low.
- adc_dat_i input 14: ADC sample, two's complement, one per clock.
- adc_photon_threshold_1 … adc_photon_threshold_7 input 14 each: thresholds, two's complement.
- photon_num_o output 3: photon number of last pulse.
- photon_valid_o output 1: one-cycle strobe, photon_num_o/overlong_o valid.
- overlong_o output 1: last pulse hit MAX_LEN.
- busy_o output 1: state ≠ IDLE.
- hist_clr_i input 1: clear all histogram bins (macro only).
- hist_sel_i input 3: bin select (macro only).
- hist_cnt_o output 32: selected bin count (macro only).

## Operation
- Input stage: adc_dat_i registered into adc_r every cycle; all comparisons are signed, 14-bit, on adc_r. prev_above = registered (adc_r > thr1).
- IDLE: on adc_r > thr1 with prev_above = 0 (rising crossing only): latch all seven thresholds into shadow registers, peak <= adc_r, len <= 1, go PULSE. Bus threshold changes during PULSE have no effect until the next pulse.
- PULSE: if adc_r > shadow_thr1: peak <= max(peak, adc_r), len <= len+1. If len == MAX_LEN → decide with overlong = 1. If adc_r <= shadow_thr1 → decide with overlong = 0; the falling sample is not included in peak.
- Decide (same edge as leaving PULSE): photon_num_o <= popcount of (peak > shadow_thr_k), k = 1..7 (strict compare; non-monotonic thresholds still give popcount); overlong_o <= overlong; photon_valid_o <= 1 for one cycle; go HOLDOFF (or IDLE if HOLDOFF = 0).
- HOLDOFF: counts HOLDOFF cycles, then IDLE; samples ignored. A signal still above thr1 on return to IDLE does not trigger; a new crossing is required.
- Result is always 1..7 because peak > thr1.
- Reset: state IDLE, photon_num_o = 0, photon_valid_o = 0, overlong_o = 0, busy_o = 0, adc_r = 0, prev_above = 0, peak/len/shadow registers = 0, hist_cnt_o = 0, all bins = 0. Reset mid-pulse aborts with no strobe.

## Timing
- Sample on adc_dat_i in cycle n: in adc_r in cycle n+1.
- First sample above thr1 in cycle n: busy_o high from cycle n+2.
- First sample at or below thr1 in cycle m: photon_valid_o high in cycle m+2, exactly one cycle; photon_num_o/overlong_o held until next strobe.
- Overlong: strobe 2 cycles after the MAX_LEN-th above-threshold sample is presented.
- Rearm: IDLE HOLDOFF cycles after the strobe cycle; busy_o low in IDLE.

## Configuration
- PNR_HISTOGRAM_EN defined:
  - Eight 32-bit saturating bins. Bin 0 counts overlong pulses; bins 1..7 count non-overlong pulses by photon_num.
  - Bins increment on the strobe edge.
  - hist_clr_i zeroes all bins on the next edge and wins over a simultaneous increment.
  - hist_cnt_o is registered from hist_sel_i with 1 cycle latency.
- PNR_HISTOGRAM_EN undefined: hist_* ports absent; no counters.

## Test plan
- Thresholds 100,200,…,700; ramp 0→450→0 in 50-step samples → single strobe, photon_num_o = 4, overlong_o = 0, at first-below-sample + 2 cycles.
- Peak exactly 200 → photon_num_o = 1 (strict compare); peak 701 → 7.
- adc_dat_i held at 1000 for MAX_LEN+10 cycles → strobe after MAX_LEN samples, photon_num_o = 7, overlong_o = 1; no retrigger until the signal falls below 100 and rises again.
- Pulse peaking at 350 while thr3 is rewritten from 300 to 400 mid-pulse → photon_num_o = 3; the next identical pulse → 2.
- Second pulse starting inside HOLDOFF = 8 → ignored, no strobe; pulse after rearm → classified. Reset asserted mid-pulse → no strobe, all outputs 0.
- With PNR_HISTOGRAM_EN: three num-2 pulses, then hist_sel_i = 2 → hist_cnt_o = 3. hist_clr_i asserted on the 4th pulse's strobe edge → bin 2 reads 0. One overlong pulse → bin 0 = 1.
